sim_finish_monitor: RTL
=======================

Name: sim_finish_monitor

Overview:
- Parametrised end-of-test monitor for Sophon simulation benches, generalising the single-core ecall/gp finish check and timeout check.
- Tracks per-hart ecall events and waits a configurable drain window, then samples each hart's gp register against a pass value.
- Runs a kickable watchdog timeout and exposes sticky done/pass/fail/timeout status.
- Instantiated by the bench next to SOPHON_TOP, one per cluster. The bench uses its outputs to call $finish.

Parameters:
- NUM_HART, 1, number of monitored harts (1..8).
- TO_BIT, 18, watchdog counter width.
- DRAIN_CYCLES, 255, cycles between trigger and gp sampling (1..65535).
- PASS_VAL, 32'd1, gp value meaning pass.
- ALL_HARTS, 1, 1 = trigger when every hart has ecalled; 0 = trigger on first ecall from any hart.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- en_i  in  1  monitor enable; low freezes all state and counters.
- ecall_i  in  NUM_HART  per-hart ecall-retire pulse.
- gp_i  in  32*NUM_HART  per-hart x3 value; hart h occupies bits [32h+31:32h].
- kick_i  in  1  watchdog restart.
- done_o  out  1  sticky; test finished by trigger or timeout.
- pass_o  out  1  sticky; gp check passed.
- fail_o  out  1  sticky; gp check failed.
- timeout_o  out  1  sticky; watchdog expired.
- hart_done_o  out  NUM_HART  sticky per-hart ecall-seen flags.
- fail_hart_o  out  3  lowest failing hart index.
- cycles_o  out  32  cycles spent in RUN and DRAIN, saturating.

Behaviour:
- Reset (async, any time, including mid-DRAIN): state=RUN, all counters 0, all outputs 0.
- States: RUN, DRAIN, DONE. DONE is terminal until reset.
- When en_i=0, no register changes (ecall_i and kick_i are ignored).
- RUN:
  - hart_done_o[h] is set on any edge with ecall_i[h]=1. It is never cleared.
  - Trigger condition uses the next-state flags (hart_done_o | ecall_i): ALL_HARTS=1 needs the AND of all bits; ALL_HARTS=0 needs the OR.
  - On trigger, go to DRAIN with drain_cnt=0.
  - Watchdog: kick_i=1 sets wd_cnt to 0 (kick beats increment). Otherwise wd_cnt increments and saturates at all-ones.
  - If wd_cnt is all-ones at an edge with no trigger, go to DONE with timeout_o=1, done_o=1, pass_o=0, fail_o=0.
  - If trigger and timeout occur on the same edge, trigger wins.
- DRAIN:
  - wd_cnt is frozen. Further ecall_i still sets hart_done_o.
  - drain_cnt increments each cycle. The edge with drain_cnt==DRAIN_CYCLES-1 enters DONE, so done_o rises exactly DRAIN_CYCLES edges after the triggering ecall edge.
- Entering DONE from DRAIN:
  - gp_i is sampled on the entering edge.
  - Only harts with hart_done_o=1 at that edge are checked.
  - pass_o=1 if every checked hart has gp==PASS_VAL. Otherwise fail_o=1, and fail_hart_o is the lowest checked hart index with a mismatch.
  - fail_hart_o=0 whenever pass_o=1 or timeout_o=1.
- Exactly one of pass_o, fail_o, timeout_o is 1 whenever done_o=1. All three are 0 while done_o=0.
- cycles_o increments in RUN and DRAIN while en_i=1, saturates at 32'hFFFFFFFF, and freezes in DONE.
- Unused hart-index bits above NUM_HART are zero.

Test Plan:
- NUM_HART=1, DRAIN_CYCLES=255: ecall at edge 100 with gp=1 -> done_o and pass_o rise at edge 355; fail_hart_o=0.
- Same configuration with gp=7 at sampling -> fail_o=1, pass_o=0, fail_hart_o=0.
- TO_BIT=4, no ecall, no kick -> timeout_o and done_o rise 16 edges after reset release. With kick_i at edge 10 -> they rise at edge 26.
- NUM_HART=4, ALL_HARTS=1: ecalls at edges 5, 9, 12, 20 with gp = 1, 1, 3, 3 and DRAIN_CYCLES=4 -> DRAIN starts at edge 20, done at edge 24, fail_o=1, fail_hart_o=2.
- NUM_HART=4, ALL_HARTS=0: hart 1 ecalls at edge 8 with gp=1, others have gp=0 -> pass_o=1 (non-done harts not checked), hart_done_o=4'b0010.
- rst_i pulsed mid-DRAIN -> all outputs 0 immediately. A later ecall triggers normally. With TO_BIT=4, an ecall on the same edge wd_cnt is 15 -> DRAIN entered, no timeout.

Source files
------------

// File: rtl/sim_finish_monitor.sv
// End-of-test monitor: tracks per-hart ecalls, waits a drain window, then checks
// each finished hart's gp against PASS_VAL; a kickable watchdog flags hangs.
module sim_finish_monitor #(
  parameter int unsigned NUM_HART     = 1,
  parameter int unsigned TO_BIT       = 18,
  parameter int unsigned DRAIN_CYCLES = 255,
  parameter logic [31:0] PASS_VAL     = 32'd1,
  parameter bit          ALL_HARTS    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [NUM_HART-1:0]      ecall_i,
  input  logic [32*NUM_HART-1:0]   gp_i,
  input  logic                     kick_i,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [NUM_HART-1:0]      hart_done_o,
  output logic [2:0]               fail_hart_o,
  output logic [31:0]              cycles_o
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam logic [15:0]       DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [TO_BIT-1:0] WD_MAX     = '1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [TO_BIT-1:0] sat_inc_wd(input logic [TO_BIT-1:0] v);
    return (v == WD_MAX) ? v : v + 1'b1;
  endfunction

  // Returns {mismatch, lowest mismatching hart}; scanning downward leaves the lowest.
  function automatic logic [3:0] gp_check(input logic [NUM_HART-1:0]    chk,
                                          input logic [32*NUM_HART-1:0] gp);
    logic [3:0] r;
    r = '0;
    for (int h = int'(NUM_HART) - 1; h >= 0; h--) begin
      if (chk[h] && (gp[32*h +: 32] != PASS_VAL)) r = {1'b1, 3'(h)};
    end
    return r;
  endfunction

  state_e                state_q;
  logic [NUM_HART-1:0]   hart_done_q;
  logic [TO_BIT-1:0]     wd_cnt_q;
  logic [15:0]           drain_cnt_q;
  logic [31:0]           cycles_q;
  logic                  done_q, pass_q, fail_q, timeout_q;
  logic [2:0]            fail_hart_q;

  logic [NUM_HART-1:0]   hart_done_d;
  logic                  trigger_d;
  logic [TO_BIT-1:0]     wd_cnt_d;
  logic [31:0]           cycles_d;
  logic [3:0]            gp_res_d;

  // Trigger looks at the flags as they will be after this edge.
  assign hart_done_d = hart_done_q | ecall_i;
  assign trigger_d   = ALL_HARTS ? (&hart_done_d) : (|hart_done_d);
  assign wd_cnt_d    = kick_i ? '0 : sat_inc_wd(wd_cnt_q);
  assign cycles_d    = sat_inc32(cycles_q);
  assign gp_res_d    = gp_check(hart_done_q, gp_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      hart_done_q <= '0;
      wd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_hart_q <= '0;
    end else if (en_i) begin
      case (state_q)
        ST_RUN: begin
          hart_done_q <= hart_done_d;
          cycles_q    <= cycles_d;
          wd_cnt_q    <= wd_cnt_d;
          if (trigger_d) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end else if (wd_cnt_q == WD_MAX) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          hart_done_q <= hart_done_d;
          cycles_q    <= cycles_d;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            pass_q      <= ~gp_res_d[3];
            fail_q      <= gp_res_d[3];
            fail_hart_q <= gp_res_d[3] ? gp_res_d[2:0] : 3'd0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign hart_done_o = hart_done_q;
  assign fail_hart_o = fail_hart_q;
  assign cycles_o    = cycles_q;

endmodule
